// File: rtl/div_seq.sv
// Multi-cycle restoring divider for the EX stage: 32-step shift-subtract loop
// producing {remainder, quotient}, with a stall request held until the result is ready.
`timescale 1ns/1ps

module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_req_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic             neg_quot;
  logic             neg_rem;
  logic             stall_req;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step, quot_step, rem_fix, quot_fix;
  logic             last_step;

  // Operand magnitudes and the single restoring step performed each ON cycle
  always_comb begin
    a_neg     = signed_div_i & opdata1_i[WIDTH-1];
    b_neg     = signed_div_i & opdata2_i[WIDTH-1];
    a_mag     = a_neg ? -opdata1_i : opdata1_i;
    b_mag     = b_neg ? -opdata2_i : opdata2_i;
    shifted   = {rem, dividend[WIDTH-1]};
    diff      = shifted - {1'b0, divisor};
    q_bit     = ~diff[WIDTH];
    rem_step  = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quot_step = {dividend[WIDTH-2:0], q_bit};
    quot_fix  = neg_quot ? -quot_step : quot_step;
    rem_fix   = neg_rem  ? -rem_step  : rem_step;
    last_step = (cnt == CW'(WIDTH-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; stall is dropped in END so the pipeline advances as the result is consumed
  always_comb begin
    state_next = state;
    stall_req  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i && !annul_i) begin
          stall_req  = 1'b1;
          state_next = (opdata2_i == '0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        stall_req  = 1'b1;
        state_next = END;
      end
      ON: begin
        if (annul_i) begin
          state_next = IDLE;
        end else begin
          stall_req = 1'b1;
          if (last_step) state_next = END;
        end
      end
      END: begin
        if (annul_i || !start_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) stall_req = 1'b0;
  end

  assign stall_req_o = stall_req;

  // Datapath: signs are captured at start so the fix-up can be applied on the final step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i && (opdata2_i != '0)) begin
            dividend <= a_mag;
            divisor  <= b_mag;
            rem      <= '0;
            cnt      <= '0;
            neg_quot <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
          end
        end
        BYZERO: begin
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        ON: begin
          if (!annul_i) begin
            dividend <= quot_step;
            rem      <= rem_step;
            cnt      <= cnt + CW'(1);
            if (last_step) begin
              result_o <= {rem_fix, quot_fix};
              ready_o  <= 1'b1;
            end
          end
        end
        END: begin
          if (annul_i || !start_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: begin
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus pushes expected results and latencies,
// a monitor pops and compares them whenever ready_o rises.
`timescale 1ns/1ps

module tb_div_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          signed_div_i;
  logic [W-1:0]  opdata1_i;
  logic [W-1:0]  opdata2_i;
  logic          start_i;
  logic          annul_i;
  logic [2*W-1:0] result_o;
  logic          ready_o;
  logic          stall_req_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int start_cyc    = 0;

  logic [63:0] exp_q[$];
  int          lat_q[$];

  logic        mon_prev = 1'b0;
  logic [63:0] mon_exp;
  int          mon_lat;

  div_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stall_req_o  (stall_req_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: every rising ready_o must match the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clk);
      if (ready_o === 1'b1 && mon_prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_ready", 64'd1, 64'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_lat = lat_q.pop_front();
          check_output("result", result_o, mon_exp);
          check_output("latency", 64'(cyc - start_cyc + 1), 64'(mon_lat));
        end
      end
      mon_prev = ready_o;
    end
  end

  // Drives one operation from cycle 1 (start already high) through consumption of the result
  task automatic run_op(input int lat, input bit rst_in_end);
    int bad;
    int n;
    bad = 0;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (stall_req_o !== (k < lat)) bad++;
      if (k == 4) begin
        opdata1_i = ~opdata1_i;
        opdata2_i = opdata2_i + 32'd5;
      end
    end
    check_output("stall_pattern", 64'(bad), 64'd0);
    n = 0;
    while (ready_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (ready_o !== 1'b1) check_output("ready_timeout", 64'd0, 64'd1);
    if (rst_in_end) begin
      #2 rst = 1'b1;
      #1;
      check_output("rst_end_ready", 64'(ready_o), 64'd0);
      check_output("rst_end_result", result_o, 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
    end else begin
      start_i = 1'b0;
      @(negedge clk);
      #1;
      check_output("drop_ready", 64'(ready_o), 64'd0);
      check_output("drop_result", result_o, 64'd0);
    end
  endtask

  task automatic apply_stimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] exp, input int lat, input bit rst_in_end);
    @(negedge clk);
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    start_cyc    = cyc;
    run_op(lat, rst_in_end);
  endtask

  localparam int NV = 9;
  logic        v_sgn [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] v_a   [NV] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'd7,
                              32'hFFFFFFF9, 32'hFFFFFFFF, 32'h00012345, 32'hFFFFFFFF};
  logic [31:0] v_b   [NV] = '{32'd2, 32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE,
                              32'hFFFFFFFE, 32'd1, 32'd0, 32'd0};
  logic [63:0] v_exp [NV] = '{64'h00000001_00000003, 64'hFFFFFFFF_FFFFFFFD,
                              64'h00000001_7FFFFFFC, 64'h00000000_80000000,
                              64'h00000001_FFFFFFFD, 64'hFFFFFFFF_00000003,
                              64'h00000000_FFFFFFFF, 64'h0, 64'h0};
  int          v_lat [NV] = '{34, 34, 34, 34, 34, 34, 34, 3, 3};
  bit          v_rst [NV] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};

  initial begin
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd9;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    #1;
    check_output("reset_stall", 64'(stall_req_o), 64'd0);
    check_output("reset_ready", 64'(ready_o), 64'd0);
    check_output("reset_result", result_o, 64'd0);
    #12 start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++)
      apply_stimulus(v_sgn[i], v_a[i], v_b[i], v_exp[i], v_lat[i], v_rst[i]);

    // Annul in the middle of ON: no result may appear
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    #1;
    check_output("annul_stall", 64'(stall_req_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    #1;
    check_output("annul_idle", 64'(stall_req_o), 64'd0);
    repeat (40) @(negedge clk);
    #1;
    check_output("annul_no_ready", 64'(ready_o), 64'd0);
    apply_stimulus(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 1'b0);

    // Asynchronous reset mid-ON, then restart with start held
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd10;
    start_i      = 1'b1;
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_output("rst_on_stall", 64'(stall_req_o), 64'd0);
    check_output("rst_on_ready", 64'(ready_o), 64'd0);
    check_output("rst_on_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(64'h00000000_00000064);
    lat_q.push_back(34);
    start_cyc = cyc;
    run_op(34, 1'b0);

    repeat (3) @(negedge clk);
    check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
